reg_loader: RTL and testbench
=============================

REG_LOADER -- requirements
Module: reg_loader

Interface
REQ-001 Parameter NUM_REGS, default 24, number of valid audio register addresses (0 to NUM_REGS-1).
REQ-002 Parameter TIMEOUT, default 25000, idle clocks allowed between bytes of one packet (about 20 bit-times at 12 MHz / 9600 baud).
REQ-003 Parameter LINK_HOLD, default 1200000, clocks the link output stays high after a completed write (100 ms at 12 MHz).
REQ-004 clk  input  1  system clock (12 MHz oscillator); the block uses one clock.
REQ-005 reset  input  1  reset; asynchronous and active-high.
REQ-006 rx_data  input  8  received serial byte; valid only when rx_valid is high.
REQ-007 rx_valid  input  1  one-clock strobe per received byte.
REQ-008 wr_ready  input  1  the audio register file accepts the pending write.
REQ-009 wr_valid  output  1  register write request.
REQ-010 wr_addr  output  5  register address.
REQ-011 wr_data  output  8  register data.
REQ-012 link  output  1  status LED: recent successful write.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err_count  output  8  saturating count of protocol errors.

Function
REQ-015 Packet format: 4 bytes in order: sync 0xA5, address, data, check. The check byte equals address XOR data.
REQ-016 FSM states: IDLE, ADDR, DATA, CHECK, WRITE. All transitions are registered and take effect on the clock edge that samples the event.
REQ-017 IDLE behaviour:
- rx_valid with rx_data = 0xA5 moves to ADDR.
- Any other byte is discarded silently; err_count is unchanged.
REQ-018 ADDR: rx_valid latches rx_data[4:0] into a held address, keeps the full byte for the check, and moves to DATA. A byte of 0xA5 is treated as an address; there is no resync.
REQ-019 DATA: rx_valid latches the data byte and moves to CHECK.
REQ-020 CHECK: rx_valid compares the byte with address XOR data.
- Match, address byte < NUM_REGS and address byte[7:5] = 0: go to WRITE.
- Otherwise: increment err_count and go to IDLE.
REQ-021 WRITE:
- wr_valid = 1, with wr_addr and wr_data held stable, starting the clock after the check byte is sampled.
- When wr_valid and wr_ready are both high at a clock edge, go to IDLE; wr_valid is 0 on the next cycle.
REQ-022 wr_valid is never high outside WRITE. wr_addr and wr_data keep their last values when idle.
REQ-023 Overrun: any rx_valid in WRITE, including the handshake cycle, drops the byte and increments err_count. The pending write is not disturbed.
REQ-024 Timeout counter:
- Cleared on entry to ADDR and on every accepted byte in ADDR, DATA and CHECK.
- Increments each clock in those three states while rx_valid is low.
- When it reaches TIMEOUT-1: go to IDLE and increment err_count.
- Does not run in IDLE or WRITE.
REQ-025 If rx_valid arrives on the same clock as the timeout, the byte wins and the counter clears.
REQ-026 Link counter:
- Loads LINK_HOLD on each completed write handshake, reloading if already running.
- Otherwise decrements to 0 and stops there.
- link = (counter != 0).
REQ-027 err_count saturates at 255. At most one increment per clock: each clock has at most one error source, because each error belongs to a distinct state.
REQ-028 Latency: the last byte sampled at edge N gives wr_valid = 1 after edge N+1. With wr_ready tied high, the write completes at edge N+2.

Reset
REQ-029 While reset is high, asynchronously:
- state = IDLE; wr_valid, wr_addr, wr_data, link, busy and err_count = 0.
- Timeout and link counters = 0.
REQ-030 Reset mid-packet or mid-write discards the packet and performs no write. After reset is released, only a new 0xA5 starts a packet.

Verification
REQ-031 Bytes A5,03,5F,5C; wr_ready=1 -> one wr_valid pulse, addr=3, data=0x5F; link high for LINK_HOLD clocks; err_count=0.
REQ-032 Bytes A5,03,5F,00 -> no wr_valid; err_count=1; busy=0. Next a valid packet A5,17,01,16 -> write addr=23, data=1.
REQ-033 Bytes A5,18,00,18 (address 24 >= NUM_REGS) -> no write; err_count+1.
REQ-034 TIMEOUT=16: A5,02 then silence -> IDLE after 15 clocks; err_count+1. A byte on the 15th clock instead -> no timeout.
REQ-035 wr_ready held 0 for 10 clocks during WRITE, with 2 bytes arriving -> wr_valid/addr/data stable all 10 clocks; err_count+2; write completes when wr_ready=1.
REQ-036 300 bad packets -> err_count=255. Reset asserted mid-packet -> all outputs 0 immediately, and a following valid packet writes correctly.

Source files
------------

// File: rtl/reg_loader.sv
// reg_loader: assembles 4-byte serial packets (0xA5, addr, data, addr^data)
// into single register writes on a valid/ready port.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-clock strobe per received byte
//   wr_ready   register file accepts the pending write
//   wr_valid   write request (held until accepted)
//   wr_addr    register address (held when idle)
//   wr_data    register data (held when idle)
//   link       high for LINK_HOLD clocks after each completed write
//   busy       high whenever a packet or write is in progress
//   err_count  saturating count of protocol errors
module reg_loader #(
  parameter int NUM_REGS  = 24,
  parameter int TIMEOUT   = 25000,
  parameter int LINK_HOLD = 1200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       wr_ready,
  output logic       wr_valid,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       link,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int LK_W = $clog2(LINK_HOLD + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, CHECK, WRITE} state_t;

  state_t            state;
  logic [7:0]        addr_byte;
  logic [7:0]        data_byte;
  logic [TO_W-1:0]   to_cnt;
  logic [LK_W-1:0]   link_cnt;

  logic in_pkt;
  logic to_hit;
  logic chk_ok;
  logic handshake;
  logic err_inc;

  assign in_pkt    = (state == ADDR) || (state == DATA) || (state == CHECK);
  // The counter is about to reach TIMEOUT-1 on this edge; a byte on the
  // same edge takes priority.
  assign to_hit    = in_pkt && !rx_valid && (to_cnt == TO_W'(TIMEOUT - 2));
  // Full address byte is range-checked so upper bits can't alias a register.
  assign chk_ok    = (rx_data == (addr_byte ^ data_byte)) &&
                     (addr_byte[7:5] == 3'd0) &&
                     ({1'b0, addr_byte} < 9'(NUM_REGS));
  assign handshake = (state == WRITE) && wr_valid && wr_ready;
  // Error sources live in distinct states, so at most one fires per clock.
  assign err_inc   = ((state == CHECK) && rx_valid && !chk_ok) ||
                     to_hit ||
                     ((state == WRITE) && rx_valid);

  assign busy = (state != IDLE);
  assign link = (link_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_byte <= '0;
      data_byte <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_count <= '0;
      to_cnt    <= '0;
      link_cnt  <= '0;
    end else begin
      if (err_inc && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      // Idle clears the counter, which also covers "cleared on entry to ADDR".
      if (in_pkt)
        to_cnt <= rx_valid ? '0 : to_cnt + TO_W'(1);
      else
        to_cnt <= '0;

      if (handshake)
        link_cnt <= LK_W'(LINK_HOLD);
      else if (link_cnt != '0)
        link_cnt <= link_cnt - LK_W'(1);

      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == 8'hA5))
            state <= ADDR;
        end
        ADDR: begin
          if (rx_valid) begin
            addr_byte <= rx_data;
            state     <= DATA;
          end else if (to_hit) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (rx_valid) begin
            data_byte <= rx_data;
            state     <= CHECK;
          end else if (to_hit) begin
            state <= IDLE;
          end
        end
        CHECK: begin
          if (rx_valid) begin
            if (chk_ok) begin
              wr_addr <= addr_byte[4:0];
              wr_data <= data_byte;
              state   <= WRITE;
            end else begin
              state <= IDLE;
            end
          end else if (to_hit) begin
            state <= IDLE;
          end
        end
        WRITE: begin
          // Request is raised one clock after entry; bytes here are dropped.
          if (!wr_valid) begin
            wr_valid <= 1'b1;
          end else if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_loader.sv
module tb_reg_loader;

  localparam int NUM_REGS  = 24;
  localparam int TIMEOUT   = 16;
  localparam int LINK_HOLD = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_ready = 1'b0;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       link;
  logic       busy;
  logic [7:0] err_count;

  reg_loader #(.NUM_REGS(NUM_REGS), .TIMEOUT(TIMEOUT), .LINK_HOLD(LINK_HOLD)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .link(link), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  exp_err = 0;
  int  checks = 0;
  int  errors = 0;
  int  ready_mode = 1;  // 0 random, 1 held low, 2 held high

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  // Reference rule for a complete packet: valid check and in-range address
  // produce one write, anything else one error.
  task automatic model_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    wr_t w;
    if ((c == (a ^ d)) && (int'(a) < NUM_REGS)) begin
      w.a = a[4:0];
      w.d = d;
      exp_q.push_back(w);
    end else begin
      bump_err();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1ns after an edge; the byte is sampled at the next edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                          input int gap);
    send(8'hA5); idle(gap);
    send(a);     idle(gap);
    send(d);     idle(gap);
    send(c);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      idle(1);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%0d pending=%0d after %0d clocks", busy, exp_q.size(), n);
    end
  endtask

  // wr_ready driver; updates 2ns after the edge so directed code can change
  // the mode at +1ns within the same cycle.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       wr_ready = ($urandom_range(0, 3) != 0);
      1:       wr_ready = 1'b0;
      default: wr_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each accepted write and checks that a
  // stalled request holds its address and data.
  initial begin
    logic       pv = 1'b0;
    logic       phs = 1'b0;
    logic [4:0] pa = '0;
    logic [7:0] pd = '0;
    wr_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (pv && !phs) begin
          chk("hold_valid", wr_valid, 1);
          chk("hold_addr", wr_addr, pa);
          chk("hold_data", wr_data, pd);
        end
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", wr_addr, e.a);
            chk("write_data", wr_data, e.d);
          end
        end
        pv  = wr_valid;
        pa  = wr_addr;
        pd  = wr_data;
        phs = wr_valid && wr_ready;
      end
    end
  end

  initial begin
    int n;
    logic [7:0] a, d, c, j;

    // Reset state, visible before any clock edge
    #1;
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_link", link, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_count, 0);
    idle(3);
    reset = 1'b0;
    idle(2);

    // Basic write, latency and link hold
    ready_mode = 2;
    idle(1);
    model_pkt(8'h03, 8'h5F, 8'h5C);
    send_pkt(8'h03, 8'h5F, 8'h5C, 1);
    chk("lat_n_valid", wr_valid, 0);
    chk("lat_n_busy", busy, 1);
    idle(1);
    chk("lat_n1_valid", wr_valid, 1);
    chk("lat_n1_addr", wr_addr, 3);
    chk("lat_n1_data", wr_data, 8'h5F);
    idle(1);
    chk("lat_n2_valid", wr_valid, 0);
    chk("lat_n2_busy", busy, 0);
    n = 0;
    while (link && n < 1000) begin
      n++;
      idle(1);
    end
    chk("link_hold", n, LINK_HOLD);
    chk("err_basic", err_count, exp_err);

    // Bad check byte, then a valid packet at the top register
    model_pkt(8'h03, 8'h5F, 8'h00);
    send_pkt(8'h03, 8'h5F, 8'h00, 0);
    chk("badchk_busy", busy, 0);
    chk("badchk_err", err_count, exp_err);
    model_pkt(8'h17, 8'h01, 8'h16);
    send_pkt(8'h17, 8'h01, 8'h16, 0);
    wait_idle();

    // Address out of range, and upper address bits set
    model_pkt(8'h18, 8'h00, 8'h18);
    send_pkt(8'h18, 8'h00, 8'h18, 0);
    idle(2);
    chk("badaddr_err", err_count, exp_err);
    model_pkt(8'h23, 8'h11, 8'h32);
    send_pkt(8'h23, 8'h11, 8'h32, 0);
    idle(2);
    chk("hiaddr_err", err_count, exp_err);
    chk("hiaddr_busy", busy, 0);

    // Timeout after 15 silent clocks; a byte on the 15th clock prevents it
    send(8'hA5);
    send(8'h02);
    idle(TIMEOUT - 2);
    chk("to_before_busy", busy, 1);
    idle(1);
    bump_err();
    chk("to_busy", busy, 0);
    chk("to_err", err_count, exp_err);
    model_pkt(8'h02, 8'h10, 8'h12);
    send(8'hA5);
    send(8'h02);
    idle(TIMEOUT - 2);
    send(8'h10);
    chk("to_saved_busy", busy, 1);
    send(8'h12);
    wait_idle();
    chk("to_saved_err", err_count, exp_err);

    // Overrun during a stalled write, including the handshake cycle
    ready_mode = 1;
    idle(1);
    model_pkt(8'h05, 8'hC3, 8'hC6);
    send_pkt(8'h05, 8'hC3, 8'hC6, 0);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", wr_valid, 1);
      chk("stall_addr", wr_addr, 5);
      chk("stall_data", wr_data, 8'hC3);
      if (i == 2 || i == 6) begin
        send(8'h5A);
        bump_err();
      end else begin
        idle(1);
      end
    end
    chk("stall_err", err_count, exp_err);
    ready_mode = 2;
    send(8'hA5);
    bump_err();
    chk("ovr_hs_valid", wr_valid, 0);
    chk("ovr_hs_busy", busy, 0);
    chk("ovr_hs_err", err_count, exp_err);
    idle(2);
    chk("ovr_no_resync", busy, 0);

    // Randomized packets against the reference rules
    ready_mode = 0;
    for (int p = 0; p < 150; p++) begin
      int kind;
      int g;
      kind = $urandom_range(0, 4);
      g    = $urandom_range(0, 4);
      d    = 8'($urandom);
      a    = 8'($urandom_range(0, NUM_REGS - 1));
      c    = a ^ d;
      if (kind == 2) c = a ^ d ^ 8'($urandom_range(1, 255));
      if (kind == 3) begin
        a = 8'($urandom_range(NUM_REGS, 255));
        c = a ^ d;
      end
      if (kind == 4) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        send(j);
        idle(g);
        send(8'hA5);
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
          idle(g);
          send(8'($urandom));
        end
        idle(TIMEOUT - 1);
        bump_err();
      end else begin
        model_pkt(a, d, c);
        send_pkt(a, d, c, g);
      end
      wait_idle();
      chk("rand_err", err_count, exp_err);
    end

    // Saturation
    ready_mode = 2;
    for (int p = 0; p < 300; p++) begin
      model_pkt(8'h01, 8'h02, 8'h00);
      send_pkt(8'h01, 8'h02, 8'h00, 0);
    end
    idle(2);
    chk("sat_err", err_count, 255);

    // Reset mid-packet
    send(8'hA5);
    send(8'h03);
    reset = 1'b1;
    #1;
    exp_err = 0;
    chk("rstpkt_busy", busy, 0);
    chk("rstpkt_err", err_count, 0);
    chk("rstpkt_link", link, 0);
    chk("rstpkt_addr", wr_addr, 0);
    idle(3);
    reset = 1'b0;

    // Reset mid-write: the pending write is discarded
    ready_mode = 1;
    idle(1);
    model_pkt(8'h04, 8'h77, 8'h73);
    send_pkt(8'h04, 8'h77, 8'h73, 0);
    idle(1);
    chk("rstwr_pre_valid", wr_valid, 1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("rstwr_valid", wr_valid, 0);
    chk("rstwr_data", wr_data, 0);
    idle(3);
    reset = 1'b0;
    ready_mode = 2;

    // Stray bytes after reset must not form a packet
    send(8'h04);
    send(8'h77);
    send(8'h73);
    idle(3);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err_count, exp_err);
    model_pkt(8'h0A, 8'hB4, 8'hBE);
    send_pkt(8'h0A, 8'hB4, 8'hBE, 1);
    wait_idle();
    chk("post_rst_err2", err_count, exp_err);
    idle(2);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
